// File: rtl/divrem_ctrl.sv
// Sequencer around a multi-cycle unsigned divider for RV32M DIV/DIVU/REM/REMU.
// Optional last-result pair cache enabled by defining DIVCTL_PAIR_CACHE_EN.
module divrem_ctrl (
  input  logic        clk,
  input  logic        cpurst,
  input  logic        req_valid,
  input  logic [1:0]  req_op,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic        flush,
  output logic        req_ready,
  output logic        busy,
  output logic        res_valid,
  output logic [31:0] res_data,
  output logic        div_start,
  output logic [31:0] div_dividend,
  output logic [31:0] div_divisor,
  input  logic        div_done,
  input  logic [31:0] div_quo,
  input  logic [31:0] div_rem
);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_FIX} state_e;

  function automatic logic [31:0] neg32(input logic [31:0] v);
    logic signed [31:0] s;
    s = $signed(v);
    return $unsigned(-s);
  endfunction

  function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic n);
    return n ? neg32(v) : v;
  endfunction

  state_e      state_q, state_d;
  logic        inflight_q, inflight_d;
  logic        ready_q, ready_d;
  logic        busy_q, busy_d;
  logic        remsel_q, remsel_d;
  logic        negq_q, negq_d;
  logic        negr_q, negr_d;
  logic [31:0] dvd_q, dvd_d;
  logic [31:0] dvs_q, dvs_d;
  logic [31:0] cq_q, cq_d;
  logic [31:0] cr_q, cr_d;
  logic [31:0] res_q, res_d;

  logic        accept, sgn, div0, ovf, hit;
  logic [31:0] fix_out;

`ifdef DIVCTL_PAIR_CACHE_EN
  logic        cvalid_q, cvalid_d;
  logic [31:0] crs1_q, crs1_d;
  logic [31:0] crs2_q, crs2_d;
  logic        csgn_q, csgn_d;
  logic [31:0] ccq_q, ccq_d;
  logic [31:0] ccr_q, ccr_d;
  logic [31:0] krs1_q, krs1_d;
  logic [31:0] krs2_q, krs2_d;
  logic        ksgn_q, ksgn_d;
`endif

  always_comb begin
    state_d    = state_q;
    inflight_d = inflight_q;
    remsel_d   = remsel_q;
    negq_d     = negq_q;
    negr_d     = negr_q;
    dvd_d      = dvd_q;
    dvs_d      = dvs_q;
    cq_d       = cq_q;
    cr_d       = cr_q;
    res_d      = res_q;
`ifdef DIVCTL_PAIR_CACHE_EN
    cvalid_d   = cvalid_q;
    crs1_d     = crs1_q;
    crs2_d     = crs2_q;
    csgn_d     = csgn_q;
    ccq_d      = ccq_q;
    ccr_d      = ccr_q;
    krs1_d     = krs1_q;
    krs2_d     = krs2_q;
    ksgn_d     = ksgn_q;
    hit        = cvalid_q && (rs1 == crs1_q) && (rs2 == crs2_q) && (req_op[0] == csgn_q);
`else
    hit        = 1'b0;
`endif

    accept    = (state_q == S_IDLE) && req_valid && ready_q && !flush;
    sgn       = ~req_op[0];
    div0      = (rs2 == 32'h0);
    ovf       = sgn && (rs1 == 32'h8000_0000) && (rs2 == 32'hFFFF_FFFF);
    fix_out   = remsel_q ? cr_q : cq_q;
    res_valid = (state_q == S_FIX) && !flush;
    res_data  = res_valid ? fix_out : res_q;
    div_start = (state_q == S_LAUNCH);

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          remsel_d = req_op[1];
          negq_d   = sgn & (rs1[31] ^ rs2[31]);
          negr_d   = sgn & rs1[31];
          dvd_d    = cond_neg(rs1, sgn & rs1[31]);
          dvs_d    = cond_neg(rs2, sgn & rs2[31]);
`ifdef DIVCTL_PAIR_CACHE_EN
          krs1_d   = rs1;
          krs2_d   = rs2;
          ksgn_d   = req_op[0];
`endif
          // Special results are known at accept; the divider is never involved.
          if (div0) begin
            cq_d    = 32'hFFFF_FFFF;
            cr_d    = rs1;
            state_d = S_FIX;
          end else if (ovf) begin
            cq_d    = 32'h8000_0000;
            cr_d    = 32'h0;
            state_d = S_FIX;
          end else if (hit) begin
`ifdef DIVCTL_PAIR_CACHE_EN
            cq_d    = ccq_q;
            cr_d    = ccr_q;
`endif
            state_d = S_FIX;
          end else begin
            state_d = S_LAUNCH;
          end
        end
      end
      S_LAUNCH: state_d = S_WAIT;
      S_WAIT: begin
        if (div_done) begin
          cq_d    = cond_neg(div_quo, negq_q);
          cr_d    = cond_neg(div_rem, negr_q);
          state_d = S_FIX;
`ifdef DIVCTL_PAIR_CACHE_EN
          if (!flush) begin
            cvalid_d = 1'b1;
            crs1_d   = krs1_q;
            crs2_d   = krs2_q;
            csgn_d   = ksgn_q;
            ccq_d    = cq_d;
            ccr_d    = cr_d;
          end
`endif
        end
      end
      S_FIX: begin
        if (!flush) res_d = fix_out;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (flush) state_d = S_IDLE;

    // Tracks the physical divider, which keeps running across a flush.
    if (div_start)     inflight_d = 1'b1;
    else if (div_done) inflight_d = 1'b0;

    ready_d = (state_d == S_IDLE) && !inflight_d;
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (cpurst) begin
      state_q    <= S_IDLE;
      inflight_q <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      res_q      <= 32'h0;
      dvd_q      <= 32'h0;
      dvs_q      <= 32'h0;
`ifdef DIVCTL_PAIR_CACHE_EN
      cvalid_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      res_q      <= res_d;
      dvd_q      <= dvd_d;
      dvs_q      <= dvs_d;
`ifdef DIVCTL_PAIR_CACHE_EN
      cvalid_q   <= cvalid_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    remsel_q <= remsel_d;
    negq_q   <= negq_d;
    negr_q   <= negr_d;
    cq_q     <= cq_d;
    cr_q     <= cr_d;
`ifdef DIVCTL_PAIR_CACHE_EN
    crs1_q   <= crs1_d;
    crs2_q   <= crs2_d;
    csgn_q   <= csgn_d;
    ccq_q    <= ccq_d;
    ccr_q    <= ccr_d;
    krs1_q   <= krs1_d;
    krs2_q   <= krs2_d;
    ksgn_q   <= ksgn_d;
`endif
  end

  assign req_ready    = ready_q;
  assign busy         = busy_q;
  assign div_dividend = dvd_q;
  assign div_divisor  = dvs_q;

endmodule

// File: tb/tb_divrem_ctrl.sv
// Directed bench for divrem_ctrl with a fixed-latency unsigned divider model.
module tb_divrem_ctrl;

`ifdef DIVCTL_PAIR_CACHE_EN
  localparam bit CACHE_ON = 1'b1;
`else
  localparam bit CACHE_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        cpurst;
  logic        req_valid;
  logic [1:0]  req_op;
  logic [31:0] rs1, rs2;
  logic        flush;
  logic        req_ready, busy, res_valid, div_start;
  logic [31:0] res_data, div_dividend, div_divisor;
  logic        div_done;
  logic [31:0] div_quo, div_rem;

  int ntests = 0;
  int nfail  = 0;
  int starts = 0;
  int dcnt   = 0;
  logic [31:0] m_dvd, m_dvs;

  always #5 clk = ~clk;

  divrem_ctrl dut (
    .clk(clk), .cpurst(cpurst), .req_valid(req_valid), .req_op(req_op),
    .rs1(rs1), .rs2(rs2), .flush(flush), .req_ready(req_ready), .busy(busy),
    .res_valid(res_valid), .res_data(res_data), .div_start(div_start),
    .div_dividend(div_dividend), .div_divisor(div_divisor), .div_done(div_done),
    .div_quo(div_quo), .div_rem(div_rem)
  );

  // Divider model: done pulse four cycles after launch is observed.
  initial begin
    div_done = 1'b0; div_quo = 32'h0; div_rem = 32'h0; m_dvd = 32'h0; m_dvs = 32'h0;
    forever begin
      @(posedge clk); #1;
      div_done = 1'b0;
      if (dcnt > 0) begin
        dcnt--;
        if (dcnt == 0) begin
          div_done = 1'b1;
          div_quo  = (m_dvs != 0) ? m_dvd / m_dvs : 32'hFFFF_FFFF;
          div_rem  = (m_dvs != 0) ? m_dvd % m_dvs : m_dvd;
        end
      end
      if (div_start) begin
        starts++;
        m_dvd = div_dividend;
        m_dvs = div_divisor;
        dcnt  = 4;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input bit fast);
    int s0;
    bit got, prev_done;
    s0 = starts;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; rs1 = a; rs2 = b;
    #1 check({tag, "_ready"}, 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    #1 check({tag, "_busy"}, 32'(busy), 32'd1);
    if (fast) begin
      check({tag, "_t1_valid"}, 32'(res_valid), 32'd1);
      check({tag, "_no_start"}, 32'(div_start), 32'd0);
    end else begin
      check({tag, "_start"}, 32'(div_start), 32'd1);
      got = 1'b0; prev_done = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
        @(negedge clk); #1;
        if (res_valid) begin
          got = 1'b1;
          check({tag, "_after_done"}, 32'(prev_done), 32'd1);
          check({tag, "_opstable"}, {div_dividend ^ m_dvd} | {div_divisor ^ m_dvs}, 32'h0);
        end
        prev_done = div_done;
      end
      check({tag, "_got_valid"}, 32'(got), 32'd1);
    end
    check({tag, "_data"}, res_data, exp);
    check({tag, "_fix_not_ready"}, 32'(req_ready), 32'd0);
    check({tag, "_starts"}, 32'(starts - s0), fast ? 32'd0 : 32'd1);
  endtask

  initial begin
    bit bad_ready, bad_valid, saw_done;
    int s0;
    cpurst = 1'b1; req_valid = 1'b0; req_op = 2'b00; rs1 = 32'h0; rs2 = 32'h0; flush = 1'b0;
    repeat (3) @(negedge clk);
    #1 check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_data", res_data, 32'h0);
    check("rst_div_start", 32'(div_start), 32'd0);
    cpurst = 1'b0;
    @(negedge clk);
    #1 check("post_rst_ready", 32'(req_ready), 32'd1);

    run_op("divu_100_7", 2'b01, 32'd100, 32'd7, 32'd14, 1'b0);
    run_op("remu_100_7", 2'b11, 32'd100, 32'd7, 32'd2, CACHE_ON);

    // Flush while the divider is running.
    s0 = starts;
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b01; rs1 = 32'd1234; rs2 = 32'd5;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    flush = 1'b1;
    #1 check("flush_no_valid", 32'(res_valid), 32'd0);
    @(negedge clk);
    flush = 1'b0;
    #1 check("flush_busy", 32'(busy), 32'd0);
    check("flush_ready_low", 32'(req_ready), 32'd0);
    bad_ready = 1'b0; bad_valid = 1'b0; saw_done = 1'b0;
    for (int i = 0; i < 40 && !saw_done; i++) begin
      if (div_done) saw_done = 1'b1;
      else begin
        if (req_ready) bad_ready = 1'b1;
        if (res_valid) bad_valid = 1'b1;
        @(negedge clk); #1;
      end
    end
    check("flush_saw_done", 32'(saw_done), 32'd1);
    check("flush_ready_held", 32'(bad_ready), 32'd0);
    check("flush_valid_held", 32'(bad_valid), 32'd0);
    check("flush_one_start", 32'(starts - s0), 32'd1);
    @(negedge clk);
    #1 check("flush_ready_after_done", 32'(req_ready), 32'd1);
    check("flush_data_kept", res_data, 32'd2);

    run_op("divu_9_3", 2'b01, 32'd9, 32'd3, 32'd3, 1'b0);

    // Flush and request together: nothing accepted.
    s0 = starts;
    @(negedge clk);
    req_valid = 1'b1; flush = 1'b1; req_op = 2'b01; rs1 = 32'd77; rs2 = 32'd7;
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b0;
    #1 check("fr_busy", 32'(busy), 32'd0);
    check("fr_res_valid", 32'(res_valid), 32'd0);
    repeat (3) @(negedge clk);
    #1 check("fr_no_start", 32'(starts - s0), 32'd0);
    check("fr_data_kept", res_data, 32'd3);

    run_op("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);
    run_op("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, CACHE_ON);
    run_op("divu_5_0", 2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1);
    run_op("remu_5_0", 2'b11, 32'd5, 32'd0, 32'd5, 1'b1);
    run_op("div_m1_0", 2'b00, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF, 1'b1);
    run_op("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
    run_op("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1'b1);
    run_op("divu_ovf_ops", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1'b0);
    run_op("remu_ovf_ops", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, CACHE_ON);
    run_op("div_1000_m3", 2'b00, 32'd1000, 32'hFFFF_FFFD, 32'hFFFF_FEB3, 1'b0);
    run_op("rem_1000_m3", 2'b10, 32'd1000, 32'hFFFF_FFFD, 32'd1, CACHE_ON);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
